divisor_frecuencia_prog: RTL

- Run-time programmable clock-enable / square-wave generator. Second generation of the team's fixed 50 MHz to 1 Hz divider.
- Adds a parametrised width and a programmable divide value with a load strobe.
- Adds a count enable and two output modes: 50 % square wave or single-cycle tick.
- Feeds the seconds/display logic of the lab designs. Its tick output is the preferred clock enable for downstream counters; do not use derived clocks.

---
 rtl/divisor_frecuencia_prog.sv | 86 ++++++++
 1 files changed

// File: rtl/divisor_frecuencia_prog.sv
// Programmable divider: square wave or one-cycle tick on reloj.
// Ports: reloj, reset, habilitar, cargar, divisor, modo -> salida, pulso.
// Optional macro DIVISOR_CUENTA_EN adds cuenta (mod-60 wraps) and minuto.
module divisor_frecuencia_prog #(
  parameter int          WIDTH       = 26,
  parameter int unsigned DIV_DEFAULT = 25000000
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             habilitar,
  input  logic             cargar,
  input  logic [WIDTH-1:0] divisor,
  input  logic             modo,
`ifdef DIVISOR_CUENTA_EN
  output logic [5:0]       cuenta,
  output logic             minuto,
`endif
  output logic             salida,
  output logic             pulso
);

  localparam logic [WIDTH-1:0] DEF = DIV_DEFAULT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] UNO = WIDTH'(1);

  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] cnt;
  logic             sal_q;
  logic [WIDTH-1:0] d_new;

  // zero is never stored: it behaves as D=1
  assign d_new = (divisor == '0) ? UNO : divisor;

  always_ff @(posedge reloj) begin
    if (reset) begin
      d_reg  <= DEF;
      cnt    <= DEF - UNO;
      sal_q  <= 1'b0;
      pulso  <= 1'b0;
      salida <= 1'b0;
    end else if (cargar) begin
      // a wrap coinciding with the load is dropped
      d_reg  <= d_new;
      cnt    <= d_new - UNO;
      sal_q  <= 1'b0;
      pulso  <= 1'b0;
      salida <= 1'b0;
    end else if (habilitar) begin
      if (cnt == '0) begin
        cnt    <= d_reg - UNO;
        sal_q  <= ~sal_q;
        pulso  <= 1'b1;
        salida <= modo ? 1'b1 : ~sal_q;
      end else begin
        cnt    <= cnt - UNO;
        pulso  <= 1'b0;
        salida <= modo ? 1'b0 : sal_q;
      end
    end else begin
      pulso  <= 1'b0;
      salida <= modo ? 1'b0 : sal_q;
    end
  end

`ifdef DIVISOR_CUENTA_EN
  logic wrap;
  assign wrap = habilitar & ~cargar & (cnt == '0);

  always_ff @(posedge reloj) begin
    if (reset || cargar) begin
      cuenta <= 6'd0;
      minuto <= 1'b0;
    end else if (wrap) begin
      if (cuenta == 6'd59) begin
        cuenta <= 6'd0;
        minuto <= 1'b1;
      end else begin
        cuenta <= cuenta + 6'd1;
        minuto <= 1'b0;
      end
    end else begin
      minuto <= 1'b0;
    end
  end
`endif

endmodule
